misa_o: RTL and testbench

- Nibble-serial accumulator CPU core implementing the MISA-O control/ALU subset: LDI, NOP, CFG, BEQZ, JAL, INC, SHL, SHR, plus XOP-prefixed BC, SA, RSA and JMP.
- Fetches 4-bit opcodes and immediates from a byte-wide instruction memory, one nibble per clock.
- Exposes ACC and carry on test ports for bench observation.
- Sits between the program memory and the system bus as the top-level processor.

---
 rtl/misa_o.sv | 161 ++++++++++++++++
 tb/tb_misa_o.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/misa_o.sv
// MISA-O nibble-serial accumulator core: fetches one 4-bit nibble per clock
// from a byte-wide program memory and executes the control/ALU subset.
module misa_o #(
  parameter logic [7:0] RESET_CFG = 8'h04
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_enable_read,
  output logic        mem_enable_write,
  input  logic [7:0]  mem_data_in,
  output logic [14:0] mem_addr,
  output logic        mem_rw,
  output logic [7:0]  mem_data_out,
  output logic [15:0] test_data,
  output logic        test_carry
);

  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {S_OPC, S_XOP2, S_IMM} state_t;
  typedef enum logic [1:0] {K_LDI, K_CFG, K_BEQZ, K_BC} kind_t;

  state_t        state_q, state_d;
  kind_t         kind_q, kind_d;
  logic [DW-1:0] pc_q, pc_d, acc_q, acc_d, ra0_q, ra0_d, ra1_q, ra1_d;
  logic [DW-1:0] base_q, base_d, imm_q, imm_d;
  logic [7:0]    cfg_q, cfg_d;
  logic          c_q, c_d;
  logic [1:0]    idx_q, idx_d, last_q, last_d;

  logic [3:0]    nib;
  logic [DW-1:0] wmask, topbit, acc_m, imm_full, br_off, br_tgt, pc_inc;
  logic [DW-1:0] inc_acc, shl_acc, shr_acc;
  logic          cin, inc_c, shl_c, shr_c;
  logic [1:0]    ldi_last, br_last;
  logic          unused_cfg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_OPC;
      kind_q  <= K_LDI;
      pc_q    <= '0;
      acc_q   <= '0;
      ra0_q   <= '0;
      ra1_q   <= '0;
      base_q  <= '0;
      imm_q   <= '0;
      cfg_q   <= RESET_CFG;
      c_q     <= 1'b0;
      idx_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ra0_q   <= ra0_d;
      ra1_q   <= ra1_d;
      base_q  <= base_d;
      imm_q   <= imm_d;
      cfg_q   <= cfg_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  // Datapath helpers: width mask from mode, ALU results, branch target.
  always_comb begin
    nib = pc_q[0] ? mem_data_in[7:4] : mem_data_in[3:0];
    case (cfg_q[2:1])
      2'b10:   begin wmask = 16'h000F; ldi_last = 2'd0; end
      2'b11:   begin wmask = 16'hFFFF; ldi_last = 2'd3; end
      default: begin wmask = 16'h00FF; ldi_last = 2'd1; end
    endcase
    topbit   = wmask ^ (wmask >> 1);
    acc_m    = acc_q & wmask;
    cin      = cfg_q[0] & c_q;
    inc_acc  = (acc_m + 16'd1) & wmask;
    inc_c    = (acc_m == wmask);
    shl_acc  = {acc_q[DW-2:0], cin} & wmask;
    shl_c    = |(acc_q & topbit);
    shr_acc  = (acc_m >> 1) | (cin ? topbit : 16'h0000);
    shr_c    = acc_q[0];
    br_last  = cfg_q[6] ? 2'd1 : 2'd0;
    imm_full = imm_q | (16'(nib) << {idx_q, 2'b00});
    br_off   = cfg_q[6] ? {{8{imm_full[7]}}, imm_full[7:0]}
                        : {{12{imm_full[3]}}, imm_full[3:0]};
    br_tgt   = base_q + (cfg_q[5] ? {br_off[DW-2:0], 1'b0} : br_off);
    pc_inc   = pc_q + 16'd1;
  end

  // Instruction sequencer: decode opcode/XOP nibble, collect immediates, execute on last nibble.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    pc_d    = pc_inc;
    acc_d   = acc_q;
    ra0_d   = ra0_q;
    ra1_d   = ra1_q;
    base_d  = base_q;
    imm_d   = imm_q;
    cfg_d   = cfg_q;
    c_d     = c_q;
    idx_d   = idx_q;
    last_d  = last_q;
    case (state_q)
      S_OPC: begin
        base_d = pc_q;
        imm_d  = '0;
        idx_d  = '0;
        case (nib)
          4'h1: begin state_d = S_IMM; kind_d = K_LDI;  last_d = ldi_last; end
          4'h2: begin state_d = S_IMM; kind_d = K_CFG;  last_d = 2'd1;     end
          4'h3: begin state_d = S_IMM; kind_d = K_BEQZ; last_d = br_last;  end
          4'h4: begin ra1_d = pc_inc; pc_d = ra0_q; end
          4'h5: begin acc_d = inc_acc; c_d = inc_c; end
          4'h6: begin acc_d = shl_acc; c_d = shl_c; end
          4'h7: begin acc_d = shr_acc; c_d = shr_c; end
          4'hF: state_d = S_XOP2;
          default: ;
        endcase
      end
      S_XOP2: begin
        state_d = S_OPC;
        case (nib)
          4'h0: begin state_d = S_IMM; kind_d = K_BC; last_d = br_last; end
          4'h1: begin acc_d = ra0_q; ra0_d = acc_q; end
          4'h2: begin ra0_d = ra1_q; ra1_d = ra0_q; end
          4'h3: pc_d = ra0_q;
          default: ;
        endcase
      end
      S_IMM: begin
        imm_d = imm_full;
        idx_d = idx_q + 2'd1;
        if (idx_q == last_q) begin
          state_d = S_OPC;
          case (kind_q)
            K_LDI:  acc_d = imm_full & wmask;
            K_CFG:  cfg_d = imm_full[7:0];
            K_BEQZ: if (acc_m == '0) pc_d = br_tgt;
            K_BC:   if (c_q) pc_d = br_tgt;
            default: ;
          endcase
        end
      end
      default: state_d = S_OPC;
    endcase
  end

  assign unused_cfg       = ^{cfg_q[7], cfg_q[4:3]};
  assign mem_enable_read  = rst;
  assign mem_enable_write = 1'b0;
  assign mem_rw           = 1'b1;
  assign mem_addr         = pc_q[15:1];
  assign mem_data_out     = acc_q[7:0];
  assign test_data        = acc_q;
  assign test_carry       = c_q;

endmodule

// File: tb/tb_misa_o.sv
// Scoreboard bench for misa_o: directed program in a byte memory, expected
// PC/ACC/C checkpoints keyed by nibble count since reset release.
module tb_misa_o;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_enable_read, mem_enable_write, mem_rw, test_carry;
  logic [7:0]  mem_data_in, mem_data_out;
  logic [14:0] mem_addr;
  logic [15:0] test_data;

  logic [7:0] mem [0:255];

  typedef struct {
    int          k;
    logic [15:0] pc;
    logic [15:0] acc;
    logic        c;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  misa_o dut (
    .clk              (clk),
    .rst              (rst),
    .mem_enable_read  (mem_enable_read),
    .mem_enable_write (mem_enable_write),
    .mem_data_in      (mem_data_in),
    .mem_addr         (mem_addr),
    .mem_rw           (mem_rw),
    .mem_data_out     (mem_data_out),
    .test_data        (test_data),
    .test_carry       (test_carry)
  );

  always #5 clk = ~clk;

  assign mem_data_in = (mem_addr < 15'd256) ? mem[mem_addr[7:0]] : 8'h00;

  // Nibbles consumed since reset release.
  always @(posedge clk) cyc <= rst ? cyc + 1 : 0;

  // Monitor: pop the next checkpoint when its nibble count is reached.
  always @(negedge clk) begin
    if (exp_q.size() != 0 && exp_q[0].k == cyc) begin
      e = exp_q.pop_front();
      n_chk++;
      if (mem_addr === e.pc[15:1] && test_data === e.acc && test_carry === e.c &&
          mem_data_out === e.acc[7:0] && mem_rw === 1'b1 && mem_enable_write === 1'b0 &&
          mem_enable_read === rst)
        n_pass++;
      else
        $display("FAIL chk@k=%0d: addr=%h acc=%h c=%b rd=%b wr=%b rw=%b dout=%h, want addr=%h acc=%h c=%b rd=%b wr=0 rw=1",
                 e.k, mem_addr, test_data, test_carry, mem_enable_read, mem_enable_write,
                 mem_rw, mem_data_out, e.pc[15:1], e.acc, e.c, rst);
    end
  end

  task automatic put(input int a, input logic [3:0] v);
    if (a[0]) mem[a >> 1][7:4] = v;
    else      mem[a >> 1][3:0] = v;
  endtask

  // Store n nibbles starting at nibble address a; leftmost hex digit goes first.
  task automatic prog(input int a, input int n, input logic [39:0] v);
    for (int i = 0; i < n; i++) put(a + i, v[4*(n-1-i) +: 4]);
  endtask

  task automatic expect_at(input int k, input logic [15:0] pc, input logic [15:0] acc, input logic c);
    exp_t x;
    x.k = k; x.pc = pc; x.acc = acc; x.c = c;
    exp_q.push_back(x);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      $display("FAIL timeout: %0d checkpoints not reached, next k=%0d", exp_q.size(), exp_q[0].k);
      n_chk += exp_q.size();
      exp_q.delete();
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    // UL mode: CFG, LDI, BEQZ taken/not, SHL, BC taken/not
    prog(1,   3, 40'h240);
    prog(4,   2, 40'h15);
    prog(6,   2, 40'h10);
    prog(12,  2, 40'h34);
    prog(14,  2, 40'h19);
    prog(16,  4, 40'h1234);
    prog(20,  3, 40'h186);
    prog(23,  4, 40'hF045);
    prog(27,  3, 40'h106);
    prog(30,  3, 40'hF04);
    // BW=8 branch, then BRS doubling
    prog(33,  3, 40'h244);
    prog(36,  3, 40'h360);
    prog(39,  2, 40'h17);
    prog(42,  3, 40'h242);
    prog(45,  4, 40'h3213);
    // LK16: LDI, SA, JAL, RSA, SA, JMP, backward BEQZ, INC/SHR/SHL
    prog(49,  3, 40'h260);
    prog(52,  5, 40'h14600);
    prog(57,  3, 40'hF14);
    prog(100, 4, 40'hF2F1);
    prog(104, 5, 40'h1C800);
    prog(109, 4, 40'hF1F3);
    prog(140, 2, 40'h38);
    prog(132, 8, 40'h57100086);

    expect_at(0,  16'd0,   16'h0000, 1'b0);
    expect_at(6,  16'd6,   16'h0005, 1'b0);
    expect_at(8,  16'd8,   16'h0000, 1'b0);
    expect_at(14, 16'd16,  16'h0000, 1'b0);
    expect_at(16, 16'd18,  16'h0002, 1'b0);
    expect_at(18, 16'd20,  16'h0002, 1'b0);
    expect_at(21, 16'd23,  16'h0000, 1'b1);
    expect_at(24, 16'd27,  16'h0000, 1'b1);
    expect_at(25, 16'd28,  16'h0000, 1'b1);
    expect_at(26, 16'd29,  16'h0000, 1'b1);
    expect_at(27, 16'd30,  16'h0000, 1'b0);
    expect_at(30, 16'd33,  16'h0000, 1'b0);
    expect_at(36, 16'd42,  16'h0000, 1'b0);
    expect_at(39, 16'd45,  16'h0000, 1'b0);
    expect_at(41, 16'd49,  16'h0000, 1'b0);
    expect_at(44, 16'd52,  16'h0000, 1'b0);
    expect_at(49, 16'd57,  16'h0064, 1'b0);
    expect_at(51, 16'd59,  16'h0000, 1'b0);
    expect_at(52, 16'd100, 16'h0000, 1'b0);
    expect_at(54, 16'd102, 16'h0000, 1'b0);
    expect_at(56, 16'd104, 16'h003C, 1'b0);
    expect_at(61, 16'd109, 16'h008C, 1'b0);
    expect_at(63, 16'd111, 16'h0000, 1'b0);
    expect_at(65, 16'd140, 16'h0000, 1'b0);
    expect_at(67, 16'd132, 16'h0000, 1'b0);
    expect_at(68, 16'd133, 16'h0001, 1'b0);
    expect_at(69, 16'd134, 16'h0000, 1'b1);
    expect_at(74, 16'd139, 16'h8000, 1'b1);
    expect_at(75, 16'd140, 16'h0000, 1'b1);

    repeat (3) @(negedge clk);
    rst = 1'b1;
    drain();

    // Reset mid-program returns to the initial state and restarts from nibble 0.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expect_at(0, 16'd0, 16'h0000, 1'b0);
    expect_at(2, 16'd2, 16'h0000, 1'b0);
    expect_at(6, 16'd6, 16'h0005, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
